// File: rtl/mux_serializer_pkg.sv
// Shared types and widths for the MUX-side serializer and its sibling stages.
package mux_serializer_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } stateT;

endpackage

// File: rtl/bit_timer.sv
// Free-running bit-period counter; tick marks the last cycle of each bit period.
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cntQ;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cntQ <= '0;
    end else if (cntQ == LastCnt) begin
      cntQ <= '0;
    end else begin
      cntQ <= cntQ + 1'b1;
    end
  end

  assign tick = (cntQ == LastCnt);

endmodule

// File: rtl/mux_serializer.sv
// Latches a word onto the 8:1 MUX inputs, walks its select through all bit positions
// and frames the selected bit as start / 8 data / stop on a UART-style line.
module mux_serializer
  import mux_serializer_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          LSB_FIRST    = 1'b1,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] inData,
  input  logic              inValid,
  output logic              inReady,
  output logic [SEL_W-1:0]  addr,
  output logic [DATA_W-1:0] muxData,
  input  logic              muxBit,
  output logic              txOut,
  output logic              busy,
  output logic              done
);

  localparam logic [SEL_W-1:0] FirstAddr = LSB_FIRST ? '0 : '1;
  // Adding all-ones is a modulo-8 decrement.
  localparam logic [SEL_W-1:0] AddrStep  = LSB_FIRST ? SEL_W'(1) : '1;

  stateT             stateQ;
  logic [SEL_W-1:0]  addrQ;
  logic [DATA_W-1:0] muxDataQ;
  logic [3:0]        bitIdxQ;
  logic              stopCntQ;
  logic              txLevelQ;
  logic              tick;
  logic              lastStop;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uBitTimer (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(stateQ == IDLE),
    .tick (tick)
  );

  assign lastStop = (stopCntQ == 1'(STOP_BITS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ   <= IDLE;
      addrQ    <= '0;
      muxDataQ <= '0;
      bitIdxQ  <= '0;
      stopCntQ <= 1'b0;
      txLevelQ <= 1'b1;
    end else begin
      case (stateQ)
        IDLE: begin
          if (inValid) begin
            muxDataQ <= inData;
            addrQ    <= FirstAddr;
            bitIdxQ  <= '0;
            txLevelQ <= 1'b0;
            stateQ   <= START;
          end
        end
        START: begin
          if (tick) stateQ <= DATA;
        end
        DATA: begin
          if (tick) begin
            bitIdxQ <= bitIdxQ + 4'd1;
            if (bitIdxQ == 4'd7) begin
              stateQ   <= STOP;
              stopCntQ <= 1'b0;
              txLevelQ <= 1'b1;
            end else begin
              addrQ <= addrQ + AddrStep;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (lastStop) stateQ <= IDLE;
            else          stopCntQ <= stopCntQ + 1'b1;
          end
        end
        default: stateQ <= IDLE;
      endcase
    end
  end

  assign inReady = (stateQ == IDLE);
  assign busy    = (stateQ != IDLE);
  assign addr    = addrQ;
  assign muxData = muxDataQ;
  assign txOut   = (stateQ == DATA) ? muxBit : txLevelQ;
  assign done    = (stateQ == STOP) && tick && lastStop;

endmodule

// File: tb/tb_mux_serializer.sv
// Directed bench: default, MSB-first and fast (1 clk/bit, 2 stop bits) serializers.
module tb_mux_serializer;

  logic clk = 1'b0;
  logic rst_n;

  logic [7:0] inDataA, inDataM, inDataF;
  logic       inValidA, inValidM, inValidF;
  logic       inReadyA, inReadyM, inReadyF;
  logic [2:0] addrA, addrM, addrF;
  logic [7:0] muxDataA, muxDataM, muxDataF;
  logic       muxBitA, muxBitM, muxBitF;
  logic       txOutA, txOutM, txOutF;
  logic       busyA, busyM, busyF;
  logic       doneA, doneM, doneF;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Behavioural 8:1 MUX downstream of each serializer.
  assign muxBitA = muxDataA[addrA];
  assign muxBitM = muxDataM[addrM];
  assign muxBitF = muxDataF[addrF];

  mux_serializer dutA (
    .clk(clk), .rst_n(rst_n), .inData(inDataA), .inValid(inValidA), .inReady(inReadyA),
    .addr(addrA), .muxData(muxDataA), .muxBit(muxBitA), .txOut(txOutA), .busy(busyA),
    .done(doneA)
  );

  mux_serializer #(.LSB_FIRST(1'b0)) dutM (
    .clk(clk), .rst_n(rst_n), .inData(inDataM), .inValid(inValidM), .inReady(inReadyM),
    .addr(addrM), .muxData(muxDataM), .muxBit(muxBitM), .txOut(txOutM), .busy(busyM),
    .done(doneM)
  );

  mux_serializer #(.CLKS_PER_BIT(1), .STOP_BITS(2)) dutF (
    .clk(clk), .rst_n(rst_n), .inData(inDataF), .inValid(inValidF), .inReady(inReadyF),
    .addr(addrF), .muxData(muxDataF), .muxBit(muxBitF), .txOut(txOutF), .busy(busyF),
    .done(doneF)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    // Data bits in transmission order (index 0 goes out first).
    logic [7:0] seqA;
    logic [7:0] seqM;
    logic [7:0] seqF;
    logic       expTx;
    logic [2:0] expAddr;
    seqA = 8'b1010_0101;  // 1,0,1,0,0,1,0,1
    seqM = 8'b1000_0000;  // 0,0,0,0,0,0,0,1
    seqF = 8'b0011_1100;  // 0,0,1,1,1,1,0,0

    rst_n = 1'b0;
    inDataA = 8'h00; inDataM = 8'h00; inDataF = 8'h00;
    inValidA = 1'b0; inValidM = 1'b0; inValidF = 1'b0;
    cyc();
    cyc();
    check("rst_txOut", txOutA, 1'b1);
    check("rst_busy", busyA, 1'b0);
    check("rst_done", doneA, 1'b0);
    check("rst_inReady", inReadyA, 1'b1);
    check("rst_addr", addrA, 3'd0);
    check("rst_muxData", muxDataA, 8'h00);
    rst_n = 1'b1;

    // Default frame, 8'hA5.
    inDataA = 8'hA5;
    inValidA = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      cyc();
      if (c == 1) inValidA = 1'b0;
      if (c <= 4) begin
        expTx = 1'b0; expAddr = 3'd0;
      end else if (c <= 36) begin
        expTx = seqA[(c - 5) / 4]; expAddr = 3'((c - 5) / 4);
      end else begin
        expTx = 1'b1; expAddr = 3'd7;
      end
      check($sformatf("a5_tx_c%0d", c), txOutA, expTx);
      check($sformatf("a5_addr_c%0d", c), addrA, expAddr);
      check($sformatf("a5_done_c%0d", c), doneA, (c == 40));
      check($sformatf("a5_busy_c%0d", c), busyA, 1'b1);
    end

    // Idle with no valid: line high, word held.
    for (int c = 1; c <= 100; c++) begin
      cyc();
      check($sformatf("idle_tx_c%0d", c), txOutA, 1'b1);
      check($sformatf("idle_busy_c%0d", c), busyA, 1'b0);
      check($sformatf("idle_done_c%0d", c), doneA, 1'b0);
      check($sformatf("idle_mux_c%0d", c), muxDataA, 8'hA5);
    end

    // Valid held high: 8'hFF then 8'h00 back to back.
    inDataA = 8'hFF;
    inValidA = 1'b1;
    for (int c = 1; c <= 42; c++) begin
      cyc();
      if (c == 1) inDataA = 8'h00;
      if (c <= 40) begin
        check($sformatf("ff_ready_c%0d", c), inReadyA, 1'b0);
        check($sformatf("ff_tx_c%0d", c), txOutA, (c > 4));
        check($sformatf("ff_done_c%0d", c), doneA, (c == 40));
      end
      if (c == 41) begin
        check("gap_ready", inReadyA, 1'b1);
        check("gap_busy", busyA, 1'b0);
        check("gap_tx", txOutA, 1'b1);
      end
      if (c == 42) begin
        check("f2_busy", busyA, 1'b1);
        check("f2_tx", txOutA, 1'b0);
        check("f2_muxData", muxDataA, 8'h00);
      end
    end

    // Reset one cycle at frame cycle 15.
    for (int k = 2; k <= 15; k++) cyc();
    check("prerst_addr", addrA, 3'd2);
    check("prerst_busy", busyA, 1'b1);
    rst_n = 1'b0;
    inValidA = 1'b0;
    cyc();
    rst_n = 1'b1;
    check("midrst_tx", txOutA, 1'b1);
    check("midrst_addr", addrA, 3'd0);
    check("midrst_busy", busyA, 1'b0);
    check("midrst_ready", inReadyA, 1'b1);
    check("midrst_done", doneA, 1'b0);
    for (int c = 1; c <= 45; c++) begin
      cyc();
      check($sformatf("postrst_done_c%0d", c), doneA, 1'b0);
      check($sformatf("postrst_busy_c%0d", c), busyA, 1'b0);
    end

    // MSB-first, 8'h01.
    inDataM = 8'h01;
    inValidM = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      cyc();
      if (c == 1) inValidM = 1'b0;
      if (c <= 4) begin
        expTx = 1'b0; expAddr = 3'd7;
      end else if (c <= 36) begin
        expTx = seqM[(c - 5) / 4]; expAddr = 3'(7 - (c - 5) / 4);
      end else begin
        expTx = 1'b1; expAddr = 3'd0;
      end
      check($sformatf("msb_tx_c%0d", c), txOutM, expTx);
      check($sformatf("msb_addr_c%0d", c), addrM, expAddr);
      check($sformatf("msb_done_c%0d", c), doneM, (c == 40));
      check($sformatf("msb_ready_c%0d", c), inReadyM, 1'b0);
    end

    // One clock per bit, two stop bits, 8'h3C: 11-cycle frame.
    inDataF = 8'h3C;
    inValidF = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      if (c == 1) inValidF = 1'b0;
      if (c == 1) begin
        expTx = 1'b0; expAddr = 3'd0;
      end else if (c <= 9) begin
        expTx = seqF[c - 2]; expAddr = 3'(c - 2);
      end else begin
        expTx = 1'b1; expAddr = 3'd7;
      end
      check($sformatf("fast_tx_c%0d", c), txOutF, expTx);
      check($sformatf("fast_addr_c%0d", c), addrF, expAddr);
      check($sformatf("fast_done_c%0d", c), doneF, (c == 11));
      check($sformatf("fast_busy_c%0d", c), busyF, (c <= 11));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
